// File: rtl/sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package sub_pkg;

    // Control states of the serial subtractor; 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default operand width and its matching bit-counter width.
    localparam int DEF_WIDTH = 4;
    localparam int CNT_W     = $clog2(DEF_WIDTH);

    // Bit-counter width for an arbitrary operand width (at least one bit).
    function automatic int cnt_bits(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout is the borrow out of this bit.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow-out of a single bit position.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; the sender holds its payload steady until that edge, and valid never
// depends combinationally on ready. Operands are taken only in IDLE; the result
// is held in DONE until the sink accepts it.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    localparam int CW = cnt_bits(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, diff_r;
    logic [CW-1:0]    cnt;
    logic             borrow, a_msb, b_msb, bout_r, ovf_r;
    logic             fs_d, fs_bout;
    logic             last_bit;

    // Single subtractor cell fed by the LSBs of the operand shift registers.
    full_subtractor u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (borrow),
        .d    (fs_d),
        .bout (fs_bout)
    );

    assign last_bit  = (state == RUN) && (cnt == LAST);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign diff      = diff_r;
    assign bout      = bout_r;
    assign ovf       = ovf_r;
    assign dbg_state = state;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: accept in IDLE, WIDTH bit steps in RUN, hold in DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last_bit)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Datapath: load operands on accept, then one bit per clock; flags at last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            diff_r <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            bout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        borrow <= bin;
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    diff_r <= {fs_d, diff_r[WIDTH-1:1]};
                    borrow <= fs_bout;
                    if (last_bit) begin
                        cnt    <= '0;
                        bout_r <= fs_bout;
                        // fs_d becomes the result MSB on this edge.
                        ovf_r  <= (a_msb ^ b_msb) & (fs_d ^ a_msb);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
